// File: rtl/mcu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcu_pkg : states, opcodes and mux-select constants for the multi-cycle   |
// |           MIPS control unit.                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mcu_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12,
    TRAP   = 4'd13
  } state_t;

  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_ADDI  = 8;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;

  localparam int ALU_ADD   = 0;
  localparam int ALU_FUNCT = 2;
  localparam int ALU_SUB   = 3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mcu_output_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcu_output_decode : combinational state/opcode -> datapath controls.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mcu_output_decode
  import mcu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
) (
  input  logic [3:0]          i_state,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_pc_write_cond,
  output logic                o_branch_ne,
  output logic                o_iord,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_mem_to_reg,
  output logic                o_alu_src_a,
  output logic                o_reg_write,
  output logic                o_reg_dst,
  output logic [1:0]          o_pc_source,
  output logic [1:0]          o_alu_src_b,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_instr_done,
  output logic                o_illegal_op
);

  state_t w_state;
  assign w_state = state_t'(i_state);

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_branch_ne     = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src_a     = 1'b0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 1'b0;
    o_pc_source     = PCSRC_ALU;
    o_alu_src_b     = SRCB_B;
    o_alu_op        = ALUOP_W'(ALU_ADD);
    o_instr_done    = 1'b0;
    o_illegal_op    = 1'b0;
    case (w_state)
      FETCH: begin
        // PC and IR only latch once memory has actually delivered the word
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      DECODE: o_alu_src_b = SRCB_IMM_SL2;
      MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
      end
      MEMWR: begin
        o_mem_write  = 1'b1;
        o_iord       = 1'b1;
        o_instr_done = i_mem_ready;
      end
      EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      ALUWB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_instr_done = 1'b1;
      end
      BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALUOP_W'(ALU_SUB);
        o_pc_write_cond = 1'b1;
        o_pc_source     = PCSRC_ALUOUT;
        o_branch_ne     = (i_opcode == OPCODE_W'(OP_BNE));
        o_instr_done    = 1'b1;
      end
      JUMP: begin
        o_pc_write   = 1'b1;
        o_pc_source  = PCSRC_JUMP;
        o_instr_done = 1'b1;
      end
      ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      TRAP:    o_illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_unit : Moore FSM sequencing the multi-cycle MIPS      |
// |                           datapath, with retired-instruction counter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int CNT_W       = 32,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNE,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count,
  output logic [3:0]          state
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_mem_ready;

  // With waiting disabled every access completes in one cycle
  assign w_mem_ready = mem_ready | (MEM_WAIT_EN == 0);

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH:  w_next = w_mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OPCODE_W'(OP_RTYPE))                                   w_next = EXEC;
        else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))   w_next = MEMADR;
        else if (opcode == OPCODE_W'(OP_BEQ) || opcode == OPCODE_W'(OP_BNE)) w_next = BRANCH;
        else if (opcode == OPCODE_W'(OP_J))                                  w_next = JUMP;
        else if (opcode == OPCODE_W'(OP_ADDI))                               w_next = ADDIEX;
        else                                                                 w_next = TRAP;
      end
      MEMADR: w_next = (opcode == OPCODE_W'(OP_LW)) ? MEMRD : MEMWR;
      MEMRD:  w_next = w_mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next = w_mem_ready ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB, TRAP: w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (instr_done) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign instr_count = r_instr_count;
  assign state       = r_state;

  mcu_output_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_output_decode (
    .i_state         (r_state),
    .i_opcode        (opcode),
    .i_mem_ready     (w_mem_ready),
    .o_pc_write      (PCWrite),
    .o_pc_write_cond (PCWriteCond),
    .o_branch_ne     (BranchNE),
    .o_iord          (IorD),
    .o_mem_read      (MemRead),
    .o_mem_write     (MemWrite),
    .o_ir_write      (IRWrite),
    .o_mem_to_reg    (MemtoReg),
    .o_alu_src_a     (ALUSrcA),
    .o_reg_write     (RegWrite),
    .o_reg_dst       (RegDst),
    .o_pc_source     (PCSource),
    .o_alu_src_b     (ALUSrcB),
    .o_alu_op        (ALUOp),
    .o_instr_done    (instr_done),
    .o_illegal_op    (illegal_op)
  );

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Successor to the single-cycle opcode decoder: a Moore FSM that sequences the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut registers) over 3–5 cycles per instruction.
- Supports R-format, lw, sw, beq, bne, j and addi, plus a memory-ready stall handshake and illegal-opcode trapping.
- Exports a retired-instruction counter.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, ALUOp width.
- CNT_W, 32, width of instr_count.
- MEM_WAIT_EN, 1, if 1 honour mem_ready; if 0 treat mem_ready as constant 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCSource  out  2  PC mux select: 0 = ALU, 1 = ALUOut, 2 = jump target.
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = signext imm, 3 = signext imm<<2.
- ALUOp  out  ALUOP_W  0 = add, 2 = funct decode, 3 = subtract/compare.
- instr_done  out  1  one-cycle pulse on the final cycle of each legal instruction.
- illegal_op  out  1  one-cycle pulse in TRAP.
- instr_count  out  CNT_W  retired legal instructions.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset: reset_n low at an edge → state = IDLE, instr_count = 0. IDLE drives every output to 0.
- IDLE → FETCH unconditionally on the next edge.
- Reset mid-instruction aborts it; any in-flight MemWrite/RegWrite deasserts on the cycle after the reset edge.
- Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite=PCWrite=mem_ready (gated). Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state by opcode:
  - 0 → EXEC
  - 35, 43 → MEMADR
  - 4, 5 → BRANCH
  - 2 → JUMP
  - 8 → ADDIEX
  - anything else → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: MEMRD if opcode=35, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready. On the ready cycle: instr_done=1 → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=3, PCWriteCond=1, PCSource=1, BranchNE=(opcode==5), instr_done=1 → FETCH.
- JUMP: PCWrite=1, PCSource=2, instr_done=1 → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0 → ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 → FETCH.
- TRAP: illegal_op=1, no writes, instr_count unchanged → FETCH.
- instr_count increments on every cycle where instr_done=1 and wraps modulo 2^CNT_W.
- Latency with mem_ready tied high (cycles from FETCH entry to last state, inclusive):
  - R: 4, lw: 5, sw: 4, addi: 4
  - beq/bne: 3, j: 3, illegal: 3
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMRD or MEMWR only. mem_ready is ignored in every other state.
- Illegal state encodings → IDLE on the next edge.

Decomposition:
- Shared package mcu_pkg holds:
  - state enum/localparams: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP;
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43;
  - ALUOp constants ALU_ADD=0, ALU_FUNCT=2, ALU_SUB=3;
  - PCSource and ALUSrcB select constants.
- One natural sub-module, mcu_output_decode: purely combinational state + opcode + mem_ready → control outputs. Next-state logic and the counter stay in the top.

Test Plan:
- reset_n low for 2 cycles mid-MEMWR → next cycle all outputs 0, state=IDLE, instr_count=0; following cycle state=FETCH with MemRead=1.
- mem_ready=1, opcode=0 → states FETCH, DECODE, EXEC, ALUWB; RegWrite=1 and RegDst=1 only in ALUWB; instr_count 0→1.
- opcode=35, mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles with MemRead=1, IorD=1; total 8 cycles; MEMWB asserts RegWrite=1, MemtoReg=1.
- opcode=5 → BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=3, PCSource=1; opcode=4 → same but BranchNE=0.
- opcode=63 → DECODE → TRAP: illegal_op pulse 1 cycle, no write enables, instr_count unchanged, back to FETCH.
- CNT_W=4: retire 17 jumps (opcode=2) → instr_count=1 (wrap), PCWrite=1 and PCSource=2 in each JUMP cycle.
